gate_ctrl: RTL

GATE_CTRL -- requirements
Module: gate_ctrl

---
 rtl/gate_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/gate_ctrl.sv
// Purpose: debounced start/stop push-buttons arm a gate that opens on TICK and closes after GATE_TICKS ticks or on stop.
// Latency: key press -> event after 2 sync + DB_CYCLES debounce cycles; ON/OFF one cycle after the deciding TICK/stop.
// Backpressure: none; TICK and key events are consumed as they arrive, start events while busy are dropped.
module gate_ctrl #(
  parameter int DB_CYCLES  = 20000,
  parameter int GATE_TICKS = 1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_key_start,
  input  logic i_key_stop,
  input  logic i_tick,
  output logic o_on,
  output logic o_off,
  output logic o_busy,
  output logic o_done
);

  localparam int              CW      = 20;
  localparam logic [CW-1:0]   DB_LAST = CW'(DB_CYCLES - 1);
  localparam logic [7:0]      GT      = 8'(GATE_TICKS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARM  = 2'd1;
  localparam logic [1:0] S_OPEN = 2'd2;

  // Index 0 is the start key, index 1 the stop key.
  logic [1:0]    w_key;
  logic [1:0]    r_sync1;
  logic [1:0]    r_sync2;
  logic [1:0]    r_db;
  logic [1:0]    r_db_d;
  logic [CW-1:0] r_db_cnt [2];

  logic [1:0]    r_state;
  logic [7:0]    r_tcnt;
  logic [7:0]    w_tcnt_inc;
  logic          w_start_ev;
  logic          w_stop_ev;
  logic          w_final_tick;
  logic          r_on;
  logic          r_off;
  logic          r_busy;
  logic          r_done;

  assign w_key = {i_key_stop, i_key_start};

  // Synchronize both keys, then accept a new level only after it has differed for DB_CYCLES consecutive cycles.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_db    <= '0;
      r_db_d  <= '0;
      for (int k = 0; k < 2; k++) r_db_cnt[k] <= '0;
    end else begin
      r_sync1 <= w_key;
      r_sync2 <= r_sync1;
      r_db_d  <= r_db;
      for (int k = 0; k < 2; k++) begin
        if (r_sync2[k] == r_db[k]) begin
          r_db_cnt[k] <= '0;
        end else if (r_db_cnt[k] == DB_LAST) begin
          r_db[k]     <= r_sync2[k];
          r_db_cnt[k] <= '0;
        end else begin
          r_db_cnt[k] <= r_db_cnt[k] + 1'b1;
        end
      end
    end
  end

  // Press events are one-cycle strobes on the rising edge of the debounced level; releases are ignored.
  assign w_start_ev   = r_db[0] & ~r_db_d[0];
  assign w_stop_ev    = r_db[1] & ~r_db_d[1];
  assign w_tcnt_inc   = r_tcnt + 8'd1;
  // The completing tick wins over a coincident stop so the window still counts as finished.
  assign w_final_tick = i_tick && (w_tcnt_inc == GT);

  // Gate sequencing: IDLE -> ARM on start, ARM -> OPEN on tick (ON pulse), OPEN -> IDLE on last tick or stop (OFF pulse).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_tcnt  <= '0;
      r_on    <= 1'b0;
      r_off   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_on  <= 1'b0;
      r_off <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start_ev && !w_stop_ev) begin
            r_state <= S_ARM;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end
        end
        S_ARM: begin
          if (w_stop_ev) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (i_tick) begin
            r_state <= S_OPEN;
            r_tcnt  <= '0;
            r_on    <= 1'b1;
          end
        end
        S_OPEN: begin
          if (w_final_tick) begin
            r_state <= S_IDLE;
            r_tcnt  <= w_tcnt_inc;
            r_busy  <= 1'b0;
            r_off   <= 1'b1;
            r_done  <= 1'b1;
          end else if (w_stop_ev) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_off   <= 1'b1;
          end else if (i_tick) begin
            r_tcnt  <= w_tcnt_inc;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_on   = r_on;
  assign o_off  = r_off;
  assign o_busy = r_busy;
  assign o_done = r_done;

endmodule
